// File: rtl/apb_slave_mem_if.sv
// APB completer bus bundle for apb_slave_mem: select/enable/address/data from the
// master, ready/error/read data back from the completer.
interface apb_slave_mem_if;
  logic       PSEL;
  logic       PEN;
  logic       PWRITE;
  logic [8:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [7:0] PRDATA;

  modport master (
    output PSEL, PEN, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PEN, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-wide register array, with parameterised wait
// states and error responses for out-of-range or read-only-region accesses.
module apb_slave_mem #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned RO_BASE     = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  apb_slave_mem_if.slave  apb
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t      state, state_next;
  logic [3:0]  wcnt, wcnt_next;
  logic        err, err_next;
  logic [7:0]  rdata, rdata_next;
  logic        ready;
  logic        mem_we;
  logic [7:0]  mem [DEPTH];

  logic [7:0]    addr;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          read_only;
  logic          addr_err;
  logic          setup;
  logic [7:0]    mem_rd;
  logic          unused_paddr_msb;

  // Bit 8 selects between completers and is decoded upstream.
  assign unused_paddr_msb = apb.PADDR[8];

  assign addr      = apb.PADDR[7:0];
  assign idx       = addr[AW-1:0];
  assign in_range  = {1'b0, addr} < 9'(DEPTH);
  assign read_only = {1'b0, addr} >= 9'(RO_BASE);
  assign addr_err  = !in_range || (apb.PWRITE && read_only);
  assign setup     = apb.PSEL && !apb.PEN;
  assign mem_rd    = in_range ? mem[idx] : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      wcnt  <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      err   <= err_next;
      rdata <= rdata_next;
    end
  end

  // A SETUP seen in either state reloads the wait count, error flag and read
  // data; in ACCESS this abandons the previous transfer without writing.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    err_next   = err;
    rdata_next = rdata;
    ready      = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_next = ACCESS;
          wcnt_next  = 4'(WAIT_STATES);
          err_next   = addr_err;
          rdata_next = (!apb.PWRITE && !addr_err) ? mem_rd : '0;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_next = IDLE;
        end else if (!apb.PEN) begin
          wcnt_next  = 4'(WAIT_STATES);
          err_next   = addr_err;
          rdata_next = (!apb.PWRITE && !addr_err) ? mem_rd : '0;
        end else if (wcnt != '0) begin
          wcnt_next = wcnt - 4'd1;
        end else begin
          ready      = 1'b1;
          mem_we     = apb.PWRITE && !err;
          state_next = IDLE;
        end
      end
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        mem[g] <= '0;
      end else if (mem_we && idx == AW'(g)) begin
        mem[g] <= apb.PWDATA;
      end
    end
  end

  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready && err;
  assign apb.PRDATA  = rdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: four instances with different wait-state and
// region settings share one bus driver, selected one at a time.
module tb_apb_slave_mem;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       psel, pen, pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic [3:0] sel;
  int unsigned cur;

  logic [3:0] rdy_v, err_v;
  logic [7:0] rd_v [4];
  logic       pready, pslverr;
  logic [7:0] prdata;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 CLK = ~CLK;

  apb_slave_mem_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign bus[g].PSEL   = psel && sel[g];
    assign bus[g].PEN    = pen;
    assign bus[g].PWRITE = pwrite;
    assign bus[g].PADDR  = paddr;
    assign bus[g].PWDATA = pwdata;
    assign rdy_v[g]      = bus[g].PREADY;
    assign err_v[g]      = bus[g].PSLVERR;
    assign rd_v[g]       = bus[g].PRDATA;
  end

  assign pready  = rdy_v[cur];
  assign pslverr = err_v[cur];
  assign prdata  = rd_v[cur];

  apb_slave_mem #(.DEPTH(256), .RO_BASE(256), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .RST_N(RST_N), .apb(bus[0]));
  apb_slave_mem #(.DEPTH(256), .RO_BASE(256), .WAIT_STATES(2)) u_ws2 (
    .CLK(CLK), .RST_N(RST_N), .apb(bus[1]));
  apb_slave_mem #(.DEPTH(256), .RO_BASE(256), .WAIT_STATES(3)) u_ws3 (
    .CLK(CLK), .RST_N(RST_N), .apb(bus[2]));
  apb_slave_mem #(.DEPTH(64), .RO_BASE(48), .WAIT_STATES(1)) u_err (
    .CLK(CLK), .RST_N(RST_N), .apb(bus[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic use_dut(input int unsigned n);
    cur = n;
    sel = 4'b0001 << n;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    psel = 1'b0;
    pen  = 1'b0;
  endtask

  // Runs one transfer; returns at the falling edge of the completing cycle so a
  // following call starts its SETUP right after completion.
  task automatic xfer(input logic wr, input logic [8:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic e, output int c);
    bit seen = 1'b0;
    @(posedge CLK); #1;
    psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    c = 1; rd = '0; e = 1'b0;
    @(posedge CLK); #1;
    pen = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      c++;
      @(negedge CLK);
      if (pready) begin
        seen = 1'b1;
        rd   = prdata;
        e    = pslverr;
      end else begin
        @(posedge CLK); #1;
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
  endtask

  task automatic txn(input string tag, input logic wr, input logic [8:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd,
                     input logic exp_err, input int exp_cyc);
    logic [7:0] rd;
    logic       e;
    int         c;
    xfer(wr, a, d, rd, e, c);
    check({tag, "_cycles"}, 32'(c), 32'(exp_cyc));
    check({tag, "_slverr"}, 32'(e), 32'(exp_err));
    if (!wr) check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    psel = 1'b0; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    use_dut(0);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_pready",  32'(pready),  32'd0);
    check("reset_pslverr", 32'(pslverr), 32'd0);
    check("reset_prdata",  32'(prdata),  32'h00);
    RST_N = 1'b1;

    // Reset during ACCESS, WAIT_STATES=2
    use_dut(1);
    txn("rst_wr",  1'b1, 9'h010, 8'h5A, 8'h00, 1'b0, 4); idle();
    txn("rst_rd0", 1'b0, 9'h010, 8'h00, 8'h5A, 1'b0, 4); idle();
    @(posedge CLK); #1;
    psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 9'h010;
    @(posedge CLK); #1;
    pen = 1'b1;
    @(negedge CLK);
    check("rst_mid_pready", 32'(pready), 32'd0);
    check("rst_mid_prdata", 32'(prdata), 32'h5A);
    #2 RST_N = 1'b0;
    #1;
    check("rst_async_pready",  32'(pready),  32'd0);
    check("rst_async_pslverr", 32'(pslverr), 32'd0);
    check("rst_async_prdata",  32'(prdata),  32'h00);
    psel = 1'b0; pen = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    txn("rst_rd1", 1'b0, 9'h010, 8'h00, 8'h00, 1'b0, 4); idle();

    // Abort: PSEL dropped in the second ACCESS cycle of a write
    txn("abt_wr", 1'b1, 9'h020, 8'h77, 8'h00, 1'b0, 4); idle();
    @(posedge CLK); #1;
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 8'h99;
    @(posedge CLK); #1;
    pen = 1'b1;
    @(negedge CLK);
    check("abt_acc1_pready", 32'(pready), 32'd0);
    @(posedge CLK); #1;
    psel = 1'b0; pen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abt_after_pready", 32'(pready), 32'd0);
    end
    txn("abt_rd", 1'b0, 9'h020, 8'h00, 8'h77, 1'b0, 4); idle();

    // Zero wait states
    use_dut(0);
    txn("zw_wr",    1'b1, 9'h010, 8'hA5, 8'h00, 1'b0, 2); idle();
    txn("zw_rd",    1'b0, 9'h010, 8'h00, 8'hA5, 1'b0, 2); idle();
    txn("zw_rd_a8", 1'b0, 9'h110, 8'h00, 8'hA5, 1'b0, 2); idle();
    txn("zw_wr_ff", 1'b1, 9'h0FF, 8'hC3, 8'h00, 1'b0, 2); idle();
    txn("zw_rd_ff", 1'b0, 9'h0FF, 8'h00, 8'hC3, 1'b0, 2); idle();

    // Back-to-back, no IDLE cycle between transfers
    txn("b2b_wr1", 1'b1, 9'h001, 8'h11, 8'h00, 1'b0, 2);
    txn("b2b_wr2", 1'b1, 9'h002, 8'h22, 8'h00, 1'b0, 2);
    txn("b2b_wr3", 1'b1, 9'h003, 8'h33, 8'h00, 1'b0, 2);
    txn("b2b_rd1", 1'b0, 9'h001, 8'h00, 8'h11, 1'b0, 2);
    txn("b2b_rd2", 1'b0, 9'h002, 8'h00, 8'h22, 1'b0, 2);
    txn("b2b_rd3", 1'b0, 9'h003, 8'h00, 8'h33, 1'b0, 2);
    idle();

    // Three wait states
    use_dut(2);
    txn("ws3_wr", 1'b1, 9'h020, 8'h3C, 8'h00, 1'b0, 5); idle();
    txn("ws3_rd", 1'b0, 9'h020, 8'h00, 8'h3C, 1'b0, 5); idle();

    // Errors: DEPTH=64, RO_BASE=48, WAIT_STATES=1
    use_dut(3);
    txn("err_wr_2f", 1'b1, 9'h02F, 8'h5E, 8'h00, 1'b0, 3); idle();
    txn("err_rd_2f", 1'b0, 9'h02F, 8'h00, 8'h5E, 1'b0, 3); idle();
    txn("err_wr_ro", 1'b1, 9'h030, 8'hFF, 8'h00, 1'b1, 3); idle();
    @(negedge CLK);
    check("err_idle_pslverr", 32'(pslverr), 32'd0);
    txn("err_rd_ro", 1'b0, 9'h030, 8'h00, 8'h00, 1'b0, 3); idle();
    txn("err_rd_3f", 1'b0, 9'h03F, 8'h00, 8'h00, 1'b0, 3); idle();
    txn("err_rd_2f2", 1'b0, 9'h02F, 8'h00, 8'h5E, 1'b0, 3);
    txn("err_rd_oor", 1'b0, 9'h050, 8'h00, 8'h00, 1'b1, 3); idle();
    txn("err_wr_40",  1'b1, 9'h040, 8'hAA, 8'h00, 1'b1, 3); idle();
    txn("err_rd_00",  1'b0, 9'h000, 8'h00, 8'h00, 1'b0, 3); idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB responder (completer) holding a byte-wide register memory, sitting behind the APB master and selected by its PSEL1/PSEL2 line. It accepts SETUP/ACCESS transfers, inserts a parameterised number of wait states, and completes each transfer with PREADY. It performs reads and writes against an internal array and flags out-of-range or write-protected accesses with PSLVERR.

## Interface

Parameters:
- DEPTH, 256: number of implemented bytes (1..256); valid offsets are PADDR[7:0] < DEPTH.
- RO_BASE, 256: first read-only offset; offsets RO_BASE..DEPTH-1 are read-only. A value of 256 means no read-only region.
- WAIT_STATES, 0: ACCESS cycles with PREADY low before completion (0..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- PSEL  in  1  slave select from master (PSEL1 or PSEL2).
- PEN  in  1  APB enable; 0 = SETUP phase, 1 = ACCESS phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  9  address. Only [7:0] is used; bit 8 is decoded by the master.
- PWDATA  in  8  write data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- PRDATA  out  8  read data; valid while PREADY=1 on reads.

## Operation

- The FSM has two states: IDLE and ACCESS. An internal 4-bit wait counter WCNT and an error flag ERR are registered.
- **Error condition** E = (PADDR[7:0] >= DEPTH) | (PWRITE & PADDR[7:0] >= RO_BASE & PADDR[7:0] < DEPTH).
- **IDLE**
  - On PSEL=1 & PEN=0 (SETUP): go to ACCESS, load WCNT=WAIT_STATES, capture ERR=E.
  - On the same edge, capture PRDATA: mem[PADDR[7:0]] if the transfer is a valid read, else 8'h00.
  - PSEL=1 & PEN=1 while in IDLE is a protocol violation. It is ignored and the FSM stays in IDLE.
- **ACCESS**
  - While PSEL=1, PEN=1 and WCNT≠0: decrement WCNT and hold PREADY=0.
  - When WCNT=0: PREADY=1 combinationally from state, WCNT, PSEL and PEN. PSLVERR=ERR.
  - On the completing edge: if PWRITE=1 and ERR=0, mem[PADDR[7:0]] ← PWDATA. The FSM returns to IDLE.
  - PSEL=0 in ACCESS aborts the transfer: the FSM returns to IDLE with no write and no PREADY.
  - PSEL=1 with PEN=0 in ACCESS is treated as a new SETUP: WCNT, ERR and PRDATA are reloaded. No write occurs for the abandoned transfer.
- **Back-to-back transfers:** the master returns to SETUP directly after completion. The slave reaches IDLE on the same edge and detects that SETUP in the following cycle.
- **Reset (asynchronous, any time)**
  - State=IDLE, WCNT=0, ERR=0, PRDATA=8'h00, and all mem bytes=8'h00.
  - PREADY=0 and PSLVERR=0.
  - A transfer in progress is dropped with no write.
- Address and data are sampled from the bus as the master holds them stable through ACCESS; they are not re-registered.

## Timing

- Read latency: SETUP cycle, then WAIT_STATES+1 ACCESS cycles, with PREADY high in the last one. Minimum 2 cycles per transfer.
- Write latency is the same. The array updates on the rising edge ending the PREADY=1 cycle and is visible to a read whose SETUP follows.
- PREADY, PSLVERR and PRDATA outside a completing cycle:
  - PREADY=0 and PSLVERR=0.
  - PRDATA holds the last captured value. It is 8'h00 after reset or after an error read.
- Error transfers take the same number of cycles as good ones; they are never shortened.

## Test plan

- **Reset:** assert RST_N=0 mid-ACCESS with WAIT_STATES=2 → PREADY=0, PSLVERR=0 and PRDATA=8'h00 immediately. After release, a read of 0x10 returns 8'h00.
- **Zero-wait write/read:** write 8'hA5 to 0x10, then read 0x10 (WAIT_STATES=0) → each transfer has PREADY=1 in its first ACCESS cycle, PSLVERR=0, and PRDATA=8'hA5.
- **Wait states:** WAIT_STATES=3, read 0x20 after writing 8'h3C → PREADY is low for 3 ACCESS cycles and high on the 4th with PRDATA=8'h3C.
- **Errors:** DEPTH=64, RO_BASE=48.
  - Write 8'hFF to 0x30 → PSLVERR=1 at PREADY, and a later read of 0x30 returns 8'h00 with PSLVERR=0.
  - Read 0x50 → PSLVERR=1, PRDATA=8'h00.
- **Abort:** PSEL dropped in the second ACCESS cycle of a write with WAIT_STATES=2 → no PREADY, and the memory is unchanged.
- **Back-to-back:** three consecutive writes to 0x01/0x02/0x03 (values 8'h11/8'h22/8'h33) with no IDLE between them, then three reads → each completes in exactly WAIT_STATES+2 cycles and returns the matching value.
